// File: rtl/step_clock_gen.sv
// ---------------------------------------------------------------------------
// step_clock_gen
//   Timing generator that sits in front of the control unit. From the system
//   clock it produces one sequencer-advance tick per instruction step and the
//   Oclk (bus-enable) / Iclk (register-set) phase levels that gate every
//   enable and set strobe. It supports free-run and debounced single-step
//   modes, and it stops cleanly at a step boundary when halt is requested.
//
//   Step shape: TICK (1 cycle), then PH_A, PH_B and PH_C (PHASE_LEN cycles
//   each). Oclk is high for PH_A..PH_C. Iclk is high for PH_B only, so bus
//   data is stable around both Iclk edges.
//
// Parameters
//   PHASE_LEN : cycles per phase, 1..255
//   DEB_LEN   : consecutive stable synchronized samples needed to accept a
//               new step_btn level, >= 1
//
// Ports
//   dclk     in   system clock, rising edge
//   reset    in   asynchronous reset, active low
//   run_mode in   1 = free-run, 0 = single-step (used at step boundaries)
//   step_btn in   raw, bouncy push-button
//   halt     in   halt request, sticky once captured
//   seq_tick out  one-cycle sequencer-advance pulse
//   Oclk     out  enable phase level
//   Iclk     out  set phase level
//   busy     out  high while a step is in progress
//   halted   out  high once halted, until reset
//   step_cnt out  completed-step counter, wraps 255 -> 0
// ---------------------------------------------------------------------------
module step_clock_gen #(
  parameter int PHASE_LEN = 4,
  parameter int DEB_LEN   = 16
) (
  input  logic       dclk,
  input  logic       reset,
  input  logic       run_mode,
  input  logic       step_btn,
  input  logic       halt,
  output logic       seq_tick,
  output logic       Oclk,
  output logic       Iclk,
  output logic       busy,
  output logic       halted,
  output logic [7:0] step_cnt
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    TICK   = 3'd1,
    PH_A   = 3'd2,
    PH_B   = 3'd3,
    PH_C   = 3'd4,
    HALTED = 3'd5
  } state_t;

  localparam logic [7:0] PHASE_LOAD = 8'(PHASE_LEN - 1);
  localparam int         DW         = (DEB_LEN > 1) ? $clog2(DEB_LEN) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_LEN - 1);

  state_t        state;
  state_t        next_state;
  logic [7:0]    phase_cnt;
  logic [7:0]    phase_cnt_nxt;
  logic          phase_last;
  logic          step_done;
  logic          consume;

  logic          sync1;
  logic          sync2;
  logic          deb_level;
  logic [DW-1:0] deb_cnt;
  logic          deb_accept;
  logic          deb_rise;

  logic          pending;
  logic          halt_l;

  assign phase_last = (phase_cnt == 8'd0);

  // The debounced level flips on the cycle that sees the DEB_LEN-th
  // consecutive differing sample. A rising flip is used in that same cycle
  // to set pending, which keeps button-to-pending latency at 2 + DEB_LEN.
  assign deb_accept = (sync2 != deb_level) && (deb_cnt == DEB_LAST);
  assign deb_rise   = deb_accept && sync2;

  // Button synchronizer and debounce counter. The counter only runs while
  // the synchronized input disagrees with the accepted level, so any bounce
  // back to the old level restarts the count.
  always_ff @(posedge dclk or negedge reset) begin
    if (!reset) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      deb_level <= 1'b0;
      deb_cnt   <= '0;
    end else begin
      sync1 <= step_btn;
      sync2 <= sync1;
      if (sync2 == deb_level) begin
        deb_cnt <= '0;
      end else if (deb_accept) begin
        deb_level <= sync2;
        deb_cnt   <= '0;
      end else begin
        deb_cnt <= deb_cnt + DW'(1);
      end
    end
  end

  // Next-state logic. The phase counter reloads on every phase entry and a
  // phase ends when it reaches zero. run_mode and halt_l are only consulted
  // in IDLE and at the end of PH_C, so a step is never cut short.
  always_comb begin
    next_state    = state;
    phase_cnt_nxt = phase_cnt;
    step_done     = 1'b0;
    consume       = 1'b0;
    case (state)
      IDLE: begin
        if (halt_l) begin
          next_state = HALTED;
        end else if (run_mode || pending) begin
          next_state = TICK;
          consume    = 1'b1;
        end
      end
      TICK: begin
        next_state    = PH_A;
        phase_cnt_nxt = PHASE_LOAD;
      end
      PH_A: begin
        if (phase_last) begin
          next_state    = PH_B;
          phase_cnt_nxt = PHASE_LOAD;
        end else begin
          phase_cnt_nxt = phase_cnt - 8'd1;
        end
      end
      PH_B: begin
        if (phase_last) begin
          next_state    = PH_C;
          phase_cnt_nxt = PHASE_LOAD;
        end else begin
          phase_cnt_nxt = phase_cnt - 8'd1;
        end
      end
      PH_C: begin
        if (phase_last) begin
          step_done = 1'b1;
          if (halt_l) begin
            next_state = HALTED;
          end else if (run_mode) begin
            next_state = TICK;
          end else begin
            next_state = IDLE;
          end
        end else begin
          phase_cnt_nxt = phase_cnt - 8'd1;
        end
      end
      HALTED: begin
        next_state = HALTED;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State, counters and request latches. Outputs are registered from
  // next_state so they line up with the state register and cannot glitch.
  // A new debounced press wins over the IDLE consume of pending, queueing
  // exactly one further step.
  always_ff @(posedge dclk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      phase_cnt <= 8'd0;
      step_cnt  <= 8'd0;
      halt_l    <= 1'b0;
      pending   <= 1'b0;
      seq_tick  <= 1'b0;
      Oclk      <= 1'b0;
      Iclk      <= 1'b0;
      busy      <= 1'b0;
      halted    <= 1'b0;
    end else begin
      state     <= next_state;
      phase_cnt <= phase_cnt_nxt;
      if (step_done) begin
        step_cnt <= step_cnt + 8'd1;
      end
      if (halt) begin
        halt_l <= 1'b1;
      end
      if (run_mode) begin
        pending <= 1'b0;
      end else if (deb_rise && (state != HALTED)) begin
        pending <= 1'b1;
      end else if (consume) begin
        pending <= 1'b0;
      end
      seq_tick <= (next_state == TICK);
      Oclk     <= (next_state == PH_A) || (next_state == PH_B) || (next_state == PH_C);
      Iclk     <= (next_state == PH_B);
      busy     <= (next_state == TICK) || (next_state == PH_A) ||
                  (next_state == PH_B) || (next_state == PH_C);
      halted   <= (next_state == HALTED);
    end
  end

endmodule
